// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice.
//   spi_state_e : transfer sequencer states
//   SPI_CPOL    : serial clock idle level (mode 2: idles high)
//   SPI_CPHA    : data is valid before the leading (falling) edge
//   SPI_WORD_W  : bits per transfer
//   SPI_EDGES   : serial clock edges per transfer
//   max3()      : elaboration helper for sizing the shared wait counter
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    GAP
  } spi_state_e;

  localparam logic        SPI_CPOL   = 1'b1;
  localparam logic        SPI_CPHA   = 1'b0;
  localparam int unsigned SPI_WORD_W = 8;
  localparam int unsigned SPI_EDGES  = 2 * SPI_WORD_W;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-request and serial-bus signals of the SPI master.
//   i_TX_DV/i_TX_DATA  : request strobe and byte to send
//   o_TX_READY         : request is accepted in a cycle where this is high
//   o_RX_DV/o_RX_DATA  : received-byte strobe and held byte
//   S_CLK/o_SS/o_MOSI  : serial clock, active-low select, serial data out
//   i_MISO             : serial data in
// modport master : the SPI master's view; modport slave : everything around it.
interface spi_master_if;
  import spi_pkg::*;

  logic                  i_TX_DV;
  logic [SPI_WORD_W-1:0] i_TX_DATA;
  logic                  o_TX_READY;
  logic                  o_RX_DV;
  logic [SPI_WORD_W-1:0] o_RX_DATA;
  logic                  S_CLK;
  logic                  o_SS;
  logic                  o_MOSI;
  logic                  i_MISO;

  modport master (
    input  i_TX_DV, i_TX_DATA, i_MISO,
    output o_TX_READY, o_RX_DV, o_RX_DATA, S_CLK, o_SS, o_MOSI
  );

  modport slave (
    output i_TX_DV, i_TX_DATA, i_MISO,
    input  o_TX_READY, o_RX_DV, o_RX_DATA, S_CLK, o_SS, o_MOSI
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Serial clock generator: half-bit counter that toggles a registered S_CLK
// every CLKS_PER_HALF_BIT cycles while enabled, and flags the cycle before
// each falling/rising edge so the caller can act on that same clock edge.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   en_i       : count/toggle enable; when low the counter clears and S_CLK idles
//   sclk_o     : registered serial clock
//   fall_stb_o : S_CLK goes low on the next rising clk edge
//   rise_stb_o : S_CLK goes high on the next rising clk edge
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic fall_stb_o,
  output logic rise_stb_o
);

  localparam int unsigned     HB_W    = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(CLKS_PER_HALF_BIT - 1);

  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            sclk_q, sclk_d;
  logic            toggle;

  always_comb begin
    toggle   = en_i && (hb_cnt_q == HB_LAST);
    hb_cnt_d = '0;
    sclk_d   = SPI_CPOL;
    if (en_i) begin
      hb_cnt_d = toggle ? '0 : hb_cnt_q + 1'b1;
      sclk_d   = toggle ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hb_cnt_q <= '0;
      sclk_q   <= SPI_CPOL;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      sclk_q   <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign fall_stb_o = toggle && sclk_q;
  assign rise_stb_o = toggle && !sclk_q;

endmodule

// File: rtl/spi_master.sv
// SPI master, mode CPOL=1/CPHA=0, one byte full duplex per transfer, MSB first.
// Sequence: IDLE -> SETUP -> TRANSFER -> HOLD -> GAP -> IDLE.
// Ports:
//   P_CLK  : clock, all logic on its rising edge
//   reset  : synchronous active-high reset (aborts any transfer)
//   bus    : spi_master_if.master (request/response handshake and serial pins)
// Build option:
//   SPI_MASTER_BURST_EN : when defined, a new request is also accepted during
//                         HOLD and chains straight into TRANSFER with o_SS held
//                         low; otherwise o_SS always deasserts between bytes.
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned CLKS_PER_HALF_BIT = 2,
  parameter int unsigned CS_SETUP_CLKS     = 2,
  parameter int unsigned CS_HOLD_CLKS      = 2,
  parameter int unsigned CS_IDLE_CLKS      = 2
) (
  input  logic             P_CLK,
  input  logic             reset,
  spi_master_if.master     bus
);

`ifdef SPI_MASTER_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  localparam int unsigned       WAIT_W     = $clog2(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS) + 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(CS_SETUP_CLKS - 1);
  localparam logic [WAIT_W-1:0] HOLD_LAST  = WAIT_W'(CS_HOLD_CLKS - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(CS_IDLE_CLKS - 1);
  localparam logic [4:0]        EDGE_LAST  = 5'(SPI_EDGES);

  spi_state_e            state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [4:0]            edge_q;
  logic [SPI_WORD_W-1:0] tx_q, rx_q, rx_data_q;
  logic                  rx_dv_q, ss_q, mosi_q;
  logic                  tx_ready, accept, sclk_en, xfer_done;
  logic                  sclk, fall_stb, rise_stb;

  spi_sclk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_sclk (
    .clk_i      (P_CLK),
    .rst_i      (reset),
    .en_i       (sclk_en),
    .sclk_o     (sclk),
    .fall_stb_o (fall_stb),
    .rise_stb_o (rise_stb)
  );

  // State register
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; wait_q counts cycles spent in the timed states
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (wait_q == SETUP_LAST) state_d = TRANSFER;
      TRANSFER: if (xfer_done) state_d = HOLD;
      HOLD: begin
        if (accept)                  state_d = TRANSFER;
        else if (wait_q == HOLD_LAST) state_d = GAP;
      end
      GAP:      if (wait_q == GAP_LAST) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    wait_d = '0;
    if ((state_d == state_q) && (state_q inside {SETUP, HOLD, GAP}))
      wait_d = wait_q + 1'b1;
  end

  // FSM outputs
  always_comb begin
    tx_ready  = (state_q == IDLE) || (BURST && (state_q == HOLD));
    accept    = bus.i_TX_DV && tx_ready;
    // Clock stops once all edges are out; S_CLK is back at its idle level then.
    sclk_en   = (state_q == TRANSFER) && (edge_q != EDGE_LAST);
    xfer_done = (state_q == TRANSFER) && (edge_q == EDGE_LAST);
  end

  // Shift registers and registered pins
  always_ff @(posedge P_CLK) begin
    if (reset) begin
      edge_q    <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      rx_dv_q   <= 1'b0;
      ss_q      <= 1'b1;
      mosi_q    <= 1'b1;
    end else begin
      rx_dv_q <= xfer_done;
      if (xfer_done) rx_data_q <= rx_q;

      if (state_q != TRANSFER)      edge_q <= '0;
      else if (fall_stb || rise_stb) edge_q <= edge_q + 5'd1;

      if (fall_stb) rx_q <= {rx_q[SPI_WORD_W-2:0], bus.i_MISO};

      // MSB goes out with the select; each following bit leaves on a rising
      // edge, except the last rising edge which has nothing left to send.
      if (accept) begin
        tx_q   <= bus.i_TX_DATA;
        mosi_q <= bus.i_TX_DATA[SPI_WORD_W-1];
        ss_q   <= 1'b0;
      end else if (rise_stb && (edge_q < 5'(SPI_EDGES - 1))) begin
        mosi_q <= tx_q[SPI_WORD_W-2];
        tx_q   <= {tx_q[SPI_WORD_W-2:0], 1'b0};
      end

      if ((state_q == HOLD) && (state_d == GAP)) begin
        ss_q   <= 1'b1;
        mosi_q <= 1'b1;
      end
    end
  end

  assign bus.o_TX_READY = tx_ready;
  assign bus.o_RX_DV    = rx_dv_q;
  assign bus.o_RX_DATA  = rx_data_q;
  assign bus.S_CLK      = sclk;
  assign bus.o_SS       = ss_q;
  assign bus.o_MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
module tb_spi_master;

  localparam int T_HALF  = 2;
  localparam int T_SETUP = 2;
  localparam int T_HOLD  = 2;
  localparam int T_GAP   = 2;
  localparam int T_HALF4 = 4;

`ifdef SPI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master_if bus ();
  spi_master_if bus4 ();

  spi_master #(
    .CLKS_PER_HALF_BIT(T_HALF),
    .CS_SETUP_CLKS    (T_SETUP),
    .CS_HOLD_CLKS     (T_HOLD),
    .CS_IDLE_CLKS     (T_GAP)
  ) dut (
    .P_CLK (clk),
    .reset (rst),
    .bus   (bus)
  );

  spi_master #(
    .CLKS_PER_HALF_BIT(T_HALF4),
    .CS_SETUP_CLKS    (T_SETUP),
    .CS_HOLD_CLKS     (T_HOLD),
    .CS_IDLE_CLKS     (T_GAP)
  ) dut4 (
    .P_CLK (clk),
    .reset (rst),
    .bus   (bus4)
  );

  assign bus4.i_MISO = bus4.o_MOSI;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
  } xfer_t;

  xfer_t      exp_q[$];
  xfer_t      exp4_q[$];
  logic [7:0] miso_q[$];

  int chk  = 0;
  int pass = 0;

  task automatic check(input string name, input int act, input int req);
    chk++;
    if (act == req) pass++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
  endtask

  // ---------------- monitor + slave model for the default-timing DUT ----------
  logic       prev_sclk = 1'b1, prev_ss = 1'b1, prev_rdy = 1'b1;
  int         edges[$];
  int         ss_fall_t = -1, ss_rise_t = -1, ready_rise_t = -1;
  int         rxdv_cnt = 0, ss_rises = 0;
  logic [7:0] mosi_cap = '0;
  logic [7:0] cur_miso = '0;
  bit         have = 1'b0;
  int         bitpos = 0;

  always @(negedge clk) begin
    if (bus.S_CLK !== prev_sclk) begin
      edges.push_back(cyc);
      if (bus.S_CLK == 1'b0) begin
        mosi_cap = {mosi_cap[6:0], bus.o_MOSI};
        if (have) begin
          bitpos++;
          if (bitpos == 8) begin
            bitpos = 0;
            have   = 1'b0;
          end
        end
      end
    end
    if (prev_ss && !bus.o_SS) ss_fall_t = cyc;
    if (!prev_ss && bus.o_SS) begin
      ss_rise_t = cyc;
      ss_rises++;
    end
    if (!prev_rdy && bus.o_TX_READY) ready_rise_t = cyc;
    prev_sclk = bus.S_CLK;
    prev_ss   = bus.o_SS;
    prev_rdy  = bus.o_TX_READY;

    if (bus.o_RX_DV) begin
      rxdv_cnt++;
      if (exp_q.size() == 0) begin
        chk++;
        $display("FAIL rx_unexpected: got o_RX_DV with data 0x%02h, required no pulse at cycle %0d",
                 bus.o_RX_DATA, cyc);
      end else begin
        xfer_t e;
        e = exp_q.pop_front();
        check("rx_data", int'(bus.o_RX_DATA), int'(e.rx));
        check("mosi_byte", int'(mosi_cap), int'(e.tx));
      end
    end

    if (!have && miso_q.size() > 0) begin
      cur_miso = miso_q.pop_front();
      have     = 1'b1;
    end
    bus.i_MISO = have ? cur_miso[7-bitpos] : 1'b1;
  end

  // ---------------- monitor for the loopback DUT ----------------
  logic prev_sclk4 = 1'b1;
  int   edges4[$];

  always @(negedge clk) begin
    if (bus4.S_CLK !== prev_sclk4) edges4.push_back(cyc);
    prev_sclk4 = bus4.S_CLK;
    if (bus4.o_RX_DV) begin
      if (exp4_q.size() == 0) begin
        chk++;
        $display("FAIL rx4_unexpected: got o_RX_DV with data 0x%02h, required no pulse at cycle %0d",
                 bus4.o_RX_DATA, cyc);
      end else begin
        xfer_t e;
        e = exp4_q.pop_front();
        check("rx4_loopback", int'(bus4.o_RX_DATA), int'(e.rx));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit on4, input int limit, input string name);
    int n;
    n = 0;
    while (!(on4 ? (bus4.o_SS && bus4.o_TX_READY) : (bus.o_SS && bus.o_TX_READY)) && n < limit) begin
      step;
      n++;
    end
    if (n >= limit) begin
      chk++;
      $display("FAIL %s: got no idle within %0d cycles, required idle", name, limit);
    end
  endtask

  task automatic wait_ready(input int limit, input string name);
    int n;
    n = 0;
    while (!bus.o_TX_READY && n < limit) begin
      step;
      n++;
    end
    if (n >= limit) begin
      chk++;
      $display("FAIL %s: got o_TX_READY=0 for %0d cycles, required 1", name, limit);
    end
  endtask

  task automatic issue(input logic [7:0] tx, input logic [7:0] rx, output int acc);
    xfer_t e;
    e.tx = tx;
    e.rx = rx;
    bus.i_TX_DATA = tx;
    bus.i_TX_DV   = 1'b1;
    acc = cyc;
    exp_q.push_back(e);
    miso_q.push_back(rx);
    step;
    bus.i_TX_DV = 1'b0;
  endtask

  task automatic issue4(input logic [7:0] tx);
    xfer_t e;
    e.tx = tx;
    e.rx = tx;
    bus4.i_TX_DATA = tx;
    bus4.i_TX_DV   = 1'b1;
    exp4_q.push_back(e);
    step;
    bus4.i_TX_DV = 1'b0;
  endtask

  function automatic int bad_spacing(input int q[$], input int half);
    int bad;
    bad = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] - q[i-1] != half) bad++;
    return bad;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int a, r0, s0;
    logic [7:0] tx, rx;
    bus.i_TX_DV    = 1'b0;
    bus.i_TX_DATA  = '0;
    bus4.i_TX_DV   = 1'b0;
    bus4.i_TX_DATA = '0;
    rst = 1'b1;
    repeat (3) step;

    check("rst_sclk",  int'(bus.S_CLK), 1);
    check("rst_ss",    int'(bus.o_SS), 1);
    check("rst_mosi",  int'(bus.o_MOSI), 1);
    check("rst_ready", int'(bus.o_TX_READY), 1);
    check("rst_rxdv",  int'(bus.o_RX_DV), 0);
    check("rst_rxdata", int'(bus.o_RX_DATA), 0);
    rst = 1'b0;
    step;

    // Directed byte with full latency profile
    edges.delete();
    issue(8'hA5, 8'h3C, a);
    wait_idle(1'b0, 100, "t1_idle");
    check("t1_ss_low", ss_fall_t - a, 1);
    check("t1_edge_count", edges.size(), 16);
    if (edges.size() > 0) check("t1_first_edge", edges[0] - a, 1 + T_SETUP + T_HALF);
    check("t1_edge_spacing", bad_spacing(edges, T_HALF), 0);
    check("t1_ss_high", ss_rise_t - a, 1 + T_SETUP + 16 * T_HALF + 1 + T_HOLD);
    check("t1_ready_high", ready_rise_t - a, 1 + T_SETUP + 16 * T_HALF + 1 + T_HOLD + T_GAP);

    // Request during a transfer is dropped
    r0 = rxdv_cnt;
    tx = 8'($urandom);
    rx = 8'($urandom);
    issue(tx, rx, a);
    while (cyc < a + 10) step;
    check("t3_ready_busy", int'(bus.o_TX_READY), 0);
    bus.i_TX_DATA = ~tx;
    bus.i_TX_DV   = 1'b1;
    step;
    bus.i_TX_DV = 1'b0;
    wait_idle(1'b0, 100, "t3_idle");
    check("t3_rx_pulses", rxdv_cnt - r0, 1);

    // Reset in the middle of a transfer
    issue(8'($urandom), 8'($urandom), a);
    while (cyc < a + 20) step;
    r0 = rxdv_cnt;
    rst = 1'b1;
    step;
    check("t4_sclk",  int'(bus.S_CLK), 1);
    check("t4_ss",    int'(bus.o_SS), 1);
    check("t4_mosi",  int'(bus.o_MOSI), 1);
    check("t4_ready", int'(bus.o_TX_READY), 1);
    check("t4_rxdv",  int'(bus.o_RX_DV), 0);
    rst = 1'b0;
    exp_q.delete();
    miso_q.delete();
    have   = 1'b0;
    bitpos = 0;
    repeat (60) step;
    check("t4_no_rx", rxdv_cnt - r0, 0);

    // Second request offered during HOLD
    edges.delete();
    r0 = rxdv_cnt;
    s0 = ss_rises;
    rx = 8'($urandom);
    issue(8'h01, rx, a);
    while (cyc < a + 1 + T_SETUP + 16 * T_HALF + 1) step;
    check("t5_hold_ready", int'(bus.o_TX_READY), int'(BURST));
    bus.i_TX_DATA = 8'h80;
    bus.i_TX_DV   = 1'b1;
    if (BURST) begin
      xfer_t e;
      e.tx = 8'h80;
      e.rx = 8'($urandom);
      exp_q.push_back(e);
      miso_q.push_back(e.rx);
    end
    step;
    bus.i_TX_DV = 1'b0;
    wait_idle(1'b0, 200, "t5_idle");
    check("t5_edges", edges.size(), BURST ? 32 : 16);
    check("t5_rx_pulses", rxdv_cnt - r0, BURST ? 2 : 1);
    check("t5_ss_rises", ss_rises - s0, 1);
    check("t5_ss_high", ss_rise_t - a,
          BURST ? (1 + T_SETUP + 16 * T_HALF + 1) + (1 + 16 * T_HALF + 1) + T_HOLD
                : (1 + T_SETUP + 16 * T_HALF + 1) + T_HOLD);

    // Slow clock build with loopback
    edges4.delete();
    issue4(8'hFF);
    wait_idle(1'b1, 200, "t6_idle_ff");
    check("t6_edges_ff", edges4.size(), 16);
    check("t6_half_ff", bad_spacing(edges4, T_HALF4), 0);
    edges4.delete();
    issue4(8'h00);
    wait_idle(1'b1, 200, "t6_idle_00");
    check("t6_edges_00", edges4.size(), 16);
    check("t6_half_00", bad_spacing(edges4, T_HALF4), 0);

    // Random traffic
    for (int i = 0; i < 20; i++) begin
      wait_ready(100, "rand_ready");
      issue(8'($urandom), 8'($urandom), a);
      repeat ($urandom_range(0, 3)) step;
    end
    wait_idle(1'b0, 200, "rand_idle");
    repeat (5) step;
    check("sb_drained", exp_q.size(), 0);
    check("sb4_drained", exp4_q.size(), 0);

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test by cycle %0d, required completion", cyc);
    $fatal(1);
  end

endmodule
